// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit pipeline: passes ALU ops straight to writeback and
// runs the load/store handshake with a multi-cycle, stallable data memory.
module mem_stage_ctrl #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_is_load,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              err
);

    // Handshake: an instruction moves from execute into this stage on a
    // rising edge where ex_valid & ex_ready; execute holds it otherwise.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              wr_q;
    logic [7:0]        cnt_q;
    logic              transfer, is_mem, bad_access;

    assign ex_ready   = (state == IDLE) & ~rst;
    assign transfer   = ex_valid & ex_ready;
    assign is_mem     = ex_mem_read | ex_mem_write;
    assign bad_access = (ex_mem_read & ex_mem_write) | ex_alu_result[0];

    // Request outputs are forced to zero outside REQ so the bus stays quiet.
    assign mem_en    = (state == REQ);
    assign mem_wr    = mem_en & wr_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign err       = (state == ERR);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (transfer && is_mem) state_next = bad_access ? ERR : REQ;
            REQ:  if (!mem_stall) state_next = WAIT;
            WAIT: begin
                if (mem_done)              state_next = IDLE;
                else if (cnt_q == CNT_LAST) state_next = ERR;
            end
            ERR:  state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            cnt_q         <= '0;
            wb_valid      <= 1'b0;
            wb_is_load    <= 1'b0;
            wb_alu_result <= '0;
            wb_rdata      <= '0;
        end else begin
            state    <= state_next;
            wb_valid <= 1'b0;
            if (state == IDLE && transfer) begin
                if (!is_mem) begin
                    wb_valid      <= 1'b1;
                    wb_is_load    <= 1'b0;
                    wb_alu_result <= ex_alu_result;
                    wb_rdata      <= '0;
                end else if (!bad_access) begin
                    addr_q  <= ex_alu_result;
                    wdata_q <= ex_wdata;
                    wr_q    <= ex_mem_write;
                end
            end
            if (state == REQ && !mem_stall) cnt_q <= '0;
            if (state == WAIT) begin
                if (mem_done) begin
                    wb_valid      <= 1'b1;
                    wb_is_load    <= ~wr_q;
                    wb_alu_result <= addr_q;
                    wb_rdata      <= wr_q ? '0 : mem_rdata;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

endmodule
